// File: rtl/tl_buf_cfg_if.sv
// TileLink five-channel bus bundle. Modports are named for the agent they face:
// Master is the view of a block sitting below a master, Slave the view of a block above a slave.
interface TL_BUS #(
    parameter int W = 32
);
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_bits;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_bits;
    logic         c_valid;
    logic         c_ready;
    logic [W-1:0] c_bits;
    logic         d_valid;
    logic         d_ready;
    logic [W-1:0] d_bits;
    logic         e_valid;
    logic         e_ready;
    logic [W-1:0] e_bits;

    modport Master (
        input  a_valid, a_bits, output a_ready,
        output b_valid, b_bits, input  b_ready,
        input  c_valid, c_bits, output c_ready,
        output d_valid, d_bits, input  d_ready,
        input  e_valid, e_bits, output e_ready
    );

    modport Slave (
        output a_valid, a_bits, input  a_ready,
        input  b_valid, b_bits, output b_ready,
        output c_valid, c_bits, input  c_ready,
        input  d_valid, d_bits, output d_ready,
        output e_valid, e_bits, input  e_ready
    );
endinterface

// File: rtl/tl_buf_cfg.sv
// Per-channel configurable TileLink buffer: bypass, pipe register or N-entry FIFO,
// with a registered idle flag covering every buffered channel.
module tl_buf_chan #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         prod_valid,
    input  logic [W-1:0] prod_bits,
    output logic         prod_ready,
    output logic         cons_valid,
    output logic [W-1:0] cons_bits,
    input  logic         cons_ready,
    output logic         busy
);
    if (DEPTH < 0) begin : g_bad_depth
        $fatal(1, "tl_buf_chan: DEPTH must be >= 0");
    end else if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;

        assign unused_clk_rst = clk_i ^ rst_i;
        assign cons_valid     = prod_valid;
        assign cons_bits      = prod_bits;
        assign prod_ready     = cons_ready;
        assign busy           = 1'b0;
    end else if (DEPTH == 1) begin : g_pipe
        logic         full;
        logic [W-1:0] data;
        logic         push;
        logic         pop;

        // Ready may look through to the consumer so a full register still sustains 1 beat/cycle.
        assign prod_ready = !full || cons_ready;
        assign push       = prod_valid && prod_ready;
        assign pop        = full && cons_ready;

        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                full <= 1'b0;
                data <= '0;
            end else if (push) begin
                full <= 1'b1;
                data <= prod_bits;
            end else if (pop) begin
                full <= 1'b0;
            end
        end

        assign cons_valid = full;
        assign cons_bits  = data;
        assign busy       = full;
    end else begin : g_fifo
        localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
        localparam int CW = $clog2(DEPTH + 1);
        localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
        localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] rptr;
        logic [PW-1:0] wptr;
        logic [CW-1:0] count;
        logic          push;
        logic          pop;

        // Ready decodes only the registered count: no consumer-to-producer combinational path.
        assign prod_ready = (count != FULL_CNT);
        assign cons_valid = (count != '0);
        assign cons_bits  = mem[rptr];
        assign push       = prod_valid && prod_ready;
        assign pop        = cons_valid && cons_ready;
        assign busy       = cons_valid;

        // NOTE: storage is reset too, so nothing from before reset is ever visible on cons_bits.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wptr] <= prod_bits;
                    wptr      <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

module tl_buf_cfg #(
    parameter int A_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int C_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int E_DEPTH = 1,
    parameter int W       = 32   // must match the W of both connected TL_BUS instances
) (
    input  logic     clk_i,
    input  logic     rst_i,
    TL_BUS.Master    in,
    TL_BUS.Slave     out,
    output logic     idle_o
);
    logic [4:0] busy;

    tl_buf_chan #(.DEPTH(A_DEPTH), .W(W)) u_a (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prod_valid (in.a_valid),
        .prod_bits  (in.a_bits),
        .prod_ready (in.a_ready),
        .cons_valid (out.a_valid),
        .cons_bits  (out.a_bits),
        .cons_ready (out.a_ready),
        .busy       (busy[0])
    );

    // B and D flow upstream: the slave side produces, the master side consumes.
    tl_buf_chan #(.DEPTH(B_DEPTH), .W(W)) u_b (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prod_valid (out.b_valid),
        .prod_bits  (out.b_bits),
        .prod_ready (out.b_ready),
        .cons_valid (in.b_valid),
        .cons_bits  (in.b_bits),
        .cons_ready (in.b_ready),
        .busy       (busy[1])
    );

    tl_buf_chan #(.DEPTH(C_DEPTH), .W(W)) u_c (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prod_valid (in.c_valid),
        .prod_bits  (in.c_bits),
        .prod_ready (in.c_ready),
        .cons_valid (out.c_valid),
        .cons_bits  (out.c_bits),
        .cons_ready (out.c_ready),
        .busy       (busy[2])
    );

    tl_buf_chan #(.DEPTH(D_DEPTH), .W(W)) u_d (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prod_valid (out.d_valid),
        .prod_bits  (out.d_bits),
        .prod_ready (out.d_ready),
        .cons_valid (in.d_valid),
        .cons_bits  (in.d_bits),
        .cons_ready (in.d_ready),
        .busy       (busy[3])
    );

    tl_buf_chan #(.DEPTH(E_DEPTH), .W(W)) u_e (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prod_valid (in.e_valid),
        .prod_bits  (in.e_bits),
        .prod_ready (in.e_ready),
        .cons_valid (out.e_valid),
        .cons_bits  (out.e_bits),
        .cons_ready (out.e_ready),
        .busy       (busy[4])
    );

    // Registered so clock-gating logic sees a glitch-free flag; it lags occupancy by one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idle_o <= 1'b1;
        end else begin
            idle_o <= ~|busy;
        end
    end
endmodule

// File: tb/tb_tl_buf_cfg.sv
// Self-checking bench for tl_buf_cfg with A=3, B=2, C=0 (bypass), D=3, E=1 (pipe).
module tb_tl_buf_cfg;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic idle_o;

    int n_cmp = 0;
    int n_err = 0;

    TL_BUS #(.W(32)) bus_in ();
    TL_BUS #(.W(32)) bus_out ();

    tl_buf_cfg #(
        .A_DEPTH (3),
        .B_DEPTH (2),
        .C_DEPTH (0),
        .D_DEPTH (3),
        .E_DEPTH (1),
        .W       (32)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .in     (bus_in),
        .out    (bus_out),
        .idle_o (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [31:0] bits;
        logic        oready;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_bits;
        logic        exp_idle;
    } a_vec_t;

    a_vec_t a_vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] dq[$];
        logic [31:0] eq[$];
        logic [31:0] cb;
        logic        cv, cr;
        int          sent, got, e_sent, e_pops;
        logic        e_full_m, exp_rdy, e_push, e_pop;

        // valid bits oready | ready ovalid obits idle  (expected = state before the edge)
        a_vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1};
        a_vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h11, 1'b1};
        a_vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h11, 1'b0};
        a_vecs[3]  = '{1'b1, 32'h1,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        a_vecs[4]  = '{1'b1, 32'h2,  1'b0, 1'b1, 1'b1, 32'h1,  1'b1};
        a_vecs[5]  = '{1'b1, 32'h3,  1'b0, 1'b1, 1'b1, 32'h1,  1'b0};
        a_vecs[6]  = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 32'h1,  1'b0};
        a_vecs[7]  = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 32'h1,  1'b0};
        a_vecs[8]  = '{1'b1, 32'h4,  1'b0, 1'b1, 1'b1, 32'h2,  1'b0};
        a_vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h2,  1'b0};
        a_vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h3,  1'b0};
        a_vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h4,  1'b0};
        a_vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        a_vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b1};

        bus_in.a_valid  = 1'b1;  bus_in.a_bits  = 32'h55;
        bus_in.c_valid  = 1'b0;  bus_in.c_bits  = '0;
        bus_in.e_valid  = 1'b0;  bus_in.e_bits  = '0;
        bus_in.b_ready  = 1'b0;  bus_in.d_ready = 1'b0;
        bus_out.b_valid = 1'b0;  bus_out.b_bits = '0;
        bus_out.d_valid = 1'b0;  bus_out.d_bits = '0;
        bus_out.a_ready = 1'b0;  bus_out.c_ready = 1'b0;
        bus_out.e_ready = 1'b0;

        // Reset held with a_valid high: nothing may be captured.
        repeat (2) @(negedge clk_i);
        check("rst_a_valid", 32'(bus_out.a_valid), 32'd0);
        check("rst_a_ready", 32'(bus_in.a_ready), 32'd1);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_d_valid", 32'(bus_in.d_valid), 32'd0);
        next_cycle();
        rst_i = 1'b1;

        // A channel FIFO (depth 3) vector table.
        foreach (a_vecs[i]) begin
            bus_in.a_valid  = a_vecs[i].valid;
            bus_in.a_bits   = a_vecs[i].bits;
            bus_out.a_ready = a_vecs[i].oready;
            @(negedge clk_i);
            check($sformatf("a_ready[%0d]", i), 32'(bus_in.a_ready), 32'(a_vecs[i].exp_ready));
            check($sformatf("a_valid[%0d]", i), 32'(bus_out.a_valid), 32'(a_vecs[i].exp_valid));
            if (a_vecs[i].exp_valid)
                check($sformatf("a_bits[%0d]", i), bus_out.a_bits, a_vecs[i].exp_bits);
            check($sformatf("idle[%0d]", i), 32'(idle_o), 32'(a_vecs[i].exp_idle));
            next_cycle();
        end

        // Reset mid-stream with two beats held in A.
        bus_in.a_valid = 1'b1; bus_in.a_bits = 32'hA1; bus_out.a_ready = 1'b0;
        next_cycle();
        bus_in.a_bits = 32'hA2;
        next_cycle();
        bus_in.a_valid = 1'b0;
        #2;
        check("pre_rst_a_valid", 32'(bus_out.a_valid), 32'd1);
        rst_i = 1'b0;
        #1;
        check("async_rst_a_valid", 32'(bus_out.a_valid), 32'd0);
        check("async_rst_a_ready", 32'(bus_in.a_ready), 32'd1);
        check("async_rst_idle", 32'(idle_o), 32'd1);
        @(negedge clk_i);
        next_cycle();
        rst_i = 1'b1;
        bus_out.a_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("post_rst_no_stale", 32'(bus_out.a_valid), 32'd0);
            check("post_rst_idle", 32'(idle_o), 32'd1);
            next_cycle();
        end
        bus_out.a_ready = 1'b0;

        // B channel (depth 2): push/pop at full and at count 1.
        bus_out.b_valid = 1'b1; bus_out.b_bits = 32'hB1; bus_in.b_ready = 1'b0;
        next_cycle();
        bus_out.b_bits = 32'hB2;
        next_cycle();
        bus_out.b_bits = 32'hB3; bus_in.b_ready = 1'b1;
        @(negedge clk_i);
        check("b_full_ready", 32'(bus_out.b_ready), 32'd0);
        check("b_full_valid", 32'(bus_in.b_valid), 32'd1);
        check("b_full_bits", bus_in.b_bits, 32'hB1);
        next_cycle();
        @(negedge clk_i);
        check("b_after_full_ready", 32'(bus_out.b_ready), 32'd1);
        check("b_after_full_bits", bus_in.b_bits, 32'hB2);
        next_cycle();
        @(negedge clk_i);
        check("b_cnt1_ready", 32'(bus_out.b_ready), 32'd1);
        check("b_cnt1_valid", 32'(bus_in.b_valid), 32'd1);
        check("b_cnt1_bits", bus_in.b_bits, 32'hB3);
        bus_out.b_valid = 1'b0;
        next_cycle();
        @(negedge clk_i);
        check("b_drained", 32'(bus_in.b_valid), 32'd0);
        bus_in.b_ready = 1'b0;
        next_cycle();

        // C channel bypass: same-cycle pass-through of bits, valid and ready.
        for (int k = 0; k < 4; k++) begin
            cv = 1'(k); cr = 1'(k >> 1); cb = $urandom;
            bus_in.c_valid = cv; bus_in.c_bits = cb; bus_out.c_ready = cr;
            #2;
            check("c_bits", bus_out.c_bits, cb);
            check("c_valid", 32'(bus_out.c_valid), 32'(cv));
            check("c_ready", 32'(bus_in.c_ready), 32'(cr));
        end
        bus_in.c_valid = 1'b0; bus_out.c_ready = 1'b0;
        next_cycle();

        // D channel (depth 3): 20-beat random-handshake stream through a scoreboard.
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            bus_out.d_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            bus_out.d_bits  = 32'(sent);
            bus_in.d_ready  = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check("d_ready", 32'(bus_out.d_ready), 32'(dq.size() != 3));
            check("d_valid", 32'(bus_in.d_valid), 32'(dq.size() != 0));
            if (bus_in.d_valid && bus_in.d_ready && dq.size() != 0) begin
                check("d_bits", bus_in.d_bits, dq.pop_front());
                got++;
            end
            if (bus_out.d_valid && bus_out.d_ready) begin
                dq.push_back(32'(sent));
                sent++;
            end
            next_cycle();
        end
        check("d_beats_delivered", 32'(got), 32'd20);
        bus_out.d_valid = 1'b0; bus_in.d_ready = 1'b0;

        // E channel pipe register: streaming, a two-cycle stall, then drain.
        e_full_m = 1'b0; e_sent = 0; e_pops = 0;
        for (int k = 0; k < 16; k++) begin
            bus_in.e_valid  = (e_sent < 10);
            bus_in.e_bits   = 32'hE0 + 32'(e_sent);
            bus_out.e_ready = !(k == 8 || k == 9);
            @(negedge clk_i);
            exp_rdy = !e_full_m || bus_out.e_ready;
            check("e_ready", 32'(bus_in.e_ready), 32'(exp_rdy));
            check("e_valid", 32'(bus_out.e_valid), 32'(e_full_m));
            e_pop  = e_full_m && bus_out.e_ready;
            e_push = bus_in.e_valid && exp_rdy;
            if (e_pop && eq.size() != 0) begin
                check("e_bits", bus_out.e_bits, eq.pop_front());
                e_pops++;
            end
            if (e_push) begin
                eq.push_back(bus_in.e_bits);
                e_sent++;
            end
            e_full_m = e_push ? 1'b1 : (e_pop ? 1'b0 : e_full_m);
            next_cycle();
        end
        check("e_beats_delivered", 32'(e_pops), 32'd10);
        bus_in.e_valid = 1'b0;

        repeat (2) next_cycle();
        @(negedge clk_i);
        check("final_idle", 32'(idle_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
